// File: rtl/gpio_irq_ctrl.sv
`default_nettype none
// ============================================================================
// gpio_irq_ctrl : multi-port GPIO with debounced inputs and edge interrupts
// Revision      : 1.0
// ============================================================================
module gpio_irq_ctrl #(
    parameter int N_PORTS = 4,
    parameter int PORT_W  = 8,
    parameter int DEB_W   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bus_valid,
    input  logic                          bus_write,
    input  logic [$clog2(N_PORTS)+2:0]    bus_addr,
    input  logic [31:0]                   bus_wdata,
    output logic [31:0]                   bus_rdata,
    output logic                          bus_rvalid,
    output logic                          bus_err,
    input  logic [N_PORTS*PORT_W-1:0]     io_in,
    output logic [N_PORTS*PORT_W-1:0]     io_out,
    output logic [N_PORTS*PORT_W-1:0]     io_oe,
    output logic                          irq
);

    localparam logic [2:0] REG_DATA_IN  = 3'd0;
    localparam logic [2:0] REG_DATA_OUT = 3'd1;
    localparam logic [2:0] REG_DIR      = 3'd2;
    localparam logic [2:0] REG_RISE_EN  = 3'd3;
    localparam logic [2:0] REG_FALL_EN  = 3'd4;
    localparam logic [2:0] REG_PEND     = 3'd5;
    localparam logic [2:0] REG_DEB_CFG  = 3'd6;

    logic [31:0]           port_idx;
    logic [2:0]            reg_sel;
    logic                  mapped;
    logic [PORT_W-1:0]     wdata;
    logic [N_PORTS*32-1:0] rd_part;
    logic [31:0]           rd_any;
    logic [N_PORTS-1:0]    pend_or;
    logic                  unused_wdata;

    assign port_idx     = 32'(bus_addr) >> 3;
    assign reg_sel      = bus_addr[2:0];
    assign mapped       = (reg_sel != 3'd7) && (port_idx < 32'(N_PORTS));
    assign wdata        = bus_wdata[PORT_W-1:0];
    assign unused_wdata = ^bus_wdata;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [PORT_W-1:0] sync1, sync2, stb;
        logic [PORT_W-1:0] data_out, dir, rise_en, fall_en, pend;
        logic [DEB_W-1:0]  cnt, deb_cfg;
        logic              sel, wr, stb_load;
        logic [PORT_W-1:0] stb_nxt, set_mask, clr_mask;
        logic [31:0]       rd_val;

        assign sel      = bus_valid && mapped && (port_idx == 32'(p));
        assign wr       = sel && bus_write;
        assign stb_load = (sync2 != stb) && (cnt == deb_cfg);
        assign stb_nxt  = stb_load ? sync2 : stb;
        // Edges are taken on the debounced value as it updates, so PEND lands with DATA_IN
        assign set_mask = (stb_nxt & ~stb & rise_en) | (~stb_nxt & stb & fall_en);
        assign clr_mask = (wr && reg_sel == REG_PEND) ? wdata : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1    <= '0;
                sync2    <= '0;
                stb      <= '0;
                cnt      <= '0;
                data_out <= '0;
                dir      <= '0;
                rise_en  <= '0;
                fall_en  <= '0;
                pend     <= '0;
                deb_cfg  <= '0;
            end else begin
                sync1 <= io_in[p*PORT_W +: PORT_W];
                sync2 <= sync1;
                if (sync2 == stb) begin
                    cnt <= '0;
                end else if (cnt == deb_cfg) begin
                    stb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DEB_W'(1);
                end
                // Hardware set is OR-ed after the clear so it wins a same-cycle W1C
                pend <= (pend & ~clr_mask) | set_mask;
                if (wr) begin
                    case (reg_sel)
                        REG_DATA_OUT: data_out <= wdata;
                        REG_DIR:      dir      <= wdata;
                        REG_RISE_EN:  rise_en  <= wdata;
                        REG_FALL_EN:  fall_en  <= wdata;
                        REG_DEB_CFG:  deb_cfg  <= bus_wdata[DEB_W-1:0];
                        default:      ;
                    endcase
                end
            end
        end

        always_comb begin
            rd_val = '0;
            case (reg_sel)
                REG_DATA_IN:  rd_val = 32'(stb);
                REG_DATA_OUT: rd_val = 32'(data_out);
                REG_DIR:      rd_val = 32'(dir);
                REG_RISE_EN:  rd_val = 32'(rise_en);
                REG_FALL_EN:  rd_val = 32'(fall_en);
                REG_PEND:     rd_val = 32'(pend);
                REG_DEB_CFG:  rd_val = 32'(deb_cfg);
                default:      rd_val = '0;
            endcase
        end

        assign rd_part[p*32 +: 32]          = sel ? rd_val : '0;
        assign pend_or[p]                   = |pend;
        assign io_out[p*PORT_W +: PORT_W]   = data_out;
        assign io_oe[p*PORT_W +: PORT_W]    = dir;
    end

    always_comb begin
        rd_any = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            rd_any = rd_any | rd_part[p*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
            bus_err    <= 1'b0;
            irq        <= 1'b0;
        end else begin
            bus_rvalid <= bus_valid && !bus_write;
            bus_rdata  <= (bus_valid && !bus_write) ? rd_any : '0;
            bus_err    <= bus_valid && !mapped;
            irq        <= |pend_or;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_ctrl.sv
`default_nettype none
// Testbench for gpio_irq_ctrl: directed bus/IO stimulus with a scoreboard
// queue of expected bus responses checked by an independent monitor.
module tb_gpio_irq_ctrl;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = $clog2(N) + 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            bus_valid, bus_write;
    logic [AW-1:0]   bus_addr;
    logic [31:0]     bus_wdata, bus_rdata;
    logic            bus_rvalid, bus_err;
    logic [N*W-1:0]  io_in, io_out, io_oe;
    logic            irq;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        er;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_tag  = 0;

    gpio_irq_ctrl #(.N_PORTS(N), .PORT_W(W), .DEB_W(D)) dut (
        .clk(clk), .reset(reset),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_err(bus_err), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic wr, input int port, input int r, input logic [31:0] d);
        bus_valid = 1'b1;
        bus_write = wr;
        bus_addr  = AW'((port << 3) | r);
        bus_wdata = d;
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic wr_ok(input int port, input int r, input logic [31:0] d);
        bus_op(1'b1, port, r, d);
    endtask

    task automatic wr_bad(input int port, input int r, input logic [31:0] d);
        n_tag++;
        q.push_back('{1'b0, 32'h0, 1'b1, n_tag});
        bus_op(1'b1, port, r, d);
    endtask

    task automatic rd(input int port, input int r, input logic [31:0] exp, input logic er);
        n_tag++;
        q.push_back('{1'b1, exp, er, n_tag});
        bus_op(1'b0, port, r, 32'h0);
    endtask

    task automatic set_io(input int port, input logic [W-1:0] v);
        io_in[port*W +: W] = v;
    endtask

    // Monitor: every bus response must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (bus_rvalid || bus_err)) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: got rvalid=%0b rdata=0x%0h err=%0b expected no response",
                             bus_rvalid, bus_rdata, bus_err);
                end else begin
                    e = q.pop_front();
                    if (bus_rvalid !== e.rv || bus_rdata !== e.rd || bus_err !== e.er) begin
                        n_fail++;
                        $display("FAIL bus_resp#%0d: got rvalid=%0b rdata=0x%0h err=%0b expected rvalid=%0b rdata=0x%0h err=%0b",
                                 e.tag, bus_rvalid, bus_rdata, bus_err, e.rv, e.rd, e.er);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; bus_valid = 1'b0; bus_write = 1'b0;
        bus_addr = '0; bus_wdata = '0; io_in = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("reset_irq", 32'(irq), 0);
        chk("reset_io_out", 32'(io_out), 0);
        chk("reset_io_oe", 32'(io_oe), 0);
        chk("reset_rvalid", 32'(bus_rvalid), 0);
        rd(0, 0, 32'h0, 1'b0);
        rd(2, 6, 32'h0, 1'b0);

        // Fast path: DEB_CFG=0, rising edge into PEND and irq
        wr_ok(0, 3, 32'h01);
        set_io(0, 8'h01);
        tick(2);
        rd(0, 0, 32'h00, 1'b0);
        chk("irq_before_pend", 32'(irq), 0);
        tick(1);
        chk("irq_rise0", 32'(irq), 1);
        rd(0, 5, 32'h01, 1'b0);
        rd(0, 0, 32'h01, 1'b0);
        wr_ok(0, 5, 32'h01);
        tick(1);
        chk("irq_clr0", 32'(irq), 0);

        // Debounce: short glitch rejected, held input accepted on the 6th cycle
        wr_ok(1, 3, 32'h80);
        wr_ok(1, 6, 32'h3);
        set_io(1, 8'h80);
        tick(2);
        set_io(1, 8'h00);
        tick(6);
        rd(1, 0, 32'h00, 1'b0);
        rd(1, 5, 32'h00, 1'b0);
        set_io(1, 8'h80);
        tick(5);
        rd(1, 0, 32'h00, 1'b0);
        rd(1, 0, 32'h80, 1'b0);
        rd(1, 5, 32'h80, 1'b0);
        wr_ok(1, 5, 32'h80);
        tick(1);
        chk("irq_clr1", 32'(irq), 0);

        // W1C partial clear on port 2
        wr_ok(2, 3, 32'h03);
        set_io(2, 8'h03);
        tick(4);
        chk("irq_port2", 32'(irq), 1);
        rd(2, 5, 32'h03, 1'b0);
        wr_ok(2, 5, 32'h01);
        rd(2, 5, 32'h02, 1'b0);
        chk("irq_partial", 32'(irq), 1);
        wr_ok(2, 5, 32'h02);
        chk("irq_hold_1cyc", 32'(irq), 1);
        tick(1);
        chk("irq_after_clr2", 32'(irq), 0);

        // Falling edge coinciding with a W1C of the same bit
        wr_ok(0, 4, 32'h01);
        set_io(0, 8'h00);
        tick(2);
        wr_ok(0, 5, 32'h01);
        rd(0, 5, 32'h01, 1'b0);
        wr_ok(0, 5, 32'h01);
        rd(0, 5, 32'h00, 1'b0);

        // Output path
        wr_ok(3, 2, 32'h0F);
        wr_ok(3, 1, 32'hA5);
        chk("io_oe3", 32'(io_oe[3*W +: W]), 32'h0F);
        chk("io_out3", 32'(io_out[3*W +: W]), 32'hA5);
        rd(3, 1, 32'hA5, 1'b0);
        rd(3, 2, 32'h0F, 1'b0);

        // Unmapped accesses
        rd(0, 7, 32'h0, 1'b1);
        rd(5, 1, 32'h0, 1'b1);
        wr_bad(5, 1, 32'hFF);
        wr_bad(3, 7, 32'hFF);
        rd(3, 1, 32'hA5, 1'b0);
        rd(4, 1, 32'h00, 1'b0);
        rd(3, 2, 32'h0F, 1'b0);

        // Reset with PEND set, then input high at release
        wr_ok(2, 4, 32'h03);
        set_io(2, 8'h00);
        tick(4);
        chk("irq_fall2", 32'(irq), 1);
        set_io(0, 8'h01);
        reset = 1'b1;
        tick(1);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_io_out", 32'(io_out), 0);
        chk("rst_io_oe", 32'(io_oe), 0);
        reset = 1'b0;
        tick(5);
        rd(0, 0, 32'h01, 1'b0);
        rd(0, 5, 32'h00, 1'b0);
        rd(3, 1, 32'h00, 1'b0);
        chk("irq_post_rst", 32'(irq), 0);

        tick(3);
        chk("queue_drain", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
